// File: rtl/wishbone_mem_interconnect_n.sv
// Single-master to N-slave Wishbone memory interconnect.
// Decodes the master address against per-slave base/mask pairs, forwards a
// base-relative request to the lowest-index matching slave, and returns one
// registered ack or bus-error pulse per transaction. Unmapped addresses and
// slaves that never ack both produce a bus error. Slave interrupts are ORed
// and registered.
module wishbone_mem_interconnect_n #(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = {NUM_SLAVES*ADDR_WIDTH{1'b0}},
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = {NUM_SLAVES*ADDR_WIDTH{1'b0}},
  parameter int TIMEOUT    = 255
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             m_we_i,
  input  logic                             m_cyc_i,
  input  logic                             m_stb_i,
  input  logic [DATA_WIDTH/8-1:0]          m_sel_i,
  input  logic [ADDR_WIDTH-1:0]            m_adr_i,
  input  logic [DATA_WIDTH-1:0]            m_dat_i,
  output logic [DATA_WIDTH-1:0]            m_dat_o,
  output logic                             m_ack_o,
  output logic                             m_err_o,
  output logic                             m_int_o,
  output logic                             s_we_o,
  output logic [NUM_SLAVES-1:0]            s_cyc_o,
  output logic [NUM_SLAVES-1:0]            s_stb_o,
  output logic [DATA_WIDTH/8-1:0]          s_sel_o,
  output logic [ADDR_WIDTH-1:0]            s_adr_o,
  output logic [DATA_WIDTH-1:0]            s_dat_o,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_dat_i,
  input  logic [NUM_SLAVES-1:0]            s_ack_i,
  input  logic [NUM_SLAVES-1:0]            s_int_i
);

  localparam int SEL_W = DATA_WIDTH / 8;
  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    ERROR  = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t                  state_q;
  logic [IDX_W-1:0]        idx_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    s_we_q;
  logic [SEL_W-1:0]        s_sel_q;
  logic [ADDR_WIDTH-1:0]   s_adr_q;
  logic [DATA_WIDTH-1:0]   s_dat_q;
  logic [NUM_SLAVES-1:0]   s_cyc_q;
  logic [NUM_SLAVES-1:0]   s_stb_q;
  logic [DATA_WIDTH-1:0]   m_dat_q;
  logic                    m_ack_q;
  logic                    m_err_q;
  logic                    m_int_q;
  logic                    m_int_d;

  logic                    hit;
  logic [IDX_W-1:0]        hit_idx;
  logic [ADDR_WIDTH-1:0]   hit_base;
  logic [NUM_SLAVES-1:0]   hit_onehot;
  logic                    sel_ack;
  logic [DATA_WIDTH-1:0]   sel_dat;

  // Address decode: scan from the top so the lowest matching index wins.
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    hit_base   = '0;
    hit_onehot = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((m_adr_i & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
          SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        hit      = 1'b1;
        hit_idx  = IDX_W'(i);
        hit_base = SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
    hit_onehot[hit_idx] = hit;
  end

  // Only the latched slave's ack and read data are ever looked at.
  always_comb begin
    sel_ack = s_ack_i[idx_q];
    sel_dat = s_dat_i[idx_q*DATA_WIDTH +: DATA_WIDTH];
  end

  // Transaction FSM with all master- and slave-facing outputs registered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      s_we_q  <= 1'b0;
      s_sel_q <= '0;
      s_adr_q <= '0;
      s_dat_q <= '0;
      s_cyc_q <= '0;
      s_stb_q <= '0;
      m_dat_q <= '0;
      m_ack_q <= 1'b0;
      m_err_q <= 1'b0;
    end else begin
      // Response strobes are single-cycle pulses by default.
      m_ack_q <= 1'b0;
      m_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (m_cyc_i && m_stb_i) begin
            if (hit) begin
              idx_q   <= hit_idx;
              s_we_q  <= m_we_i;
              s_sel_q <= m_sel_i;
              s_dat_q <= m_dat_i;
              s_adr_q <= m_adr_i - hit_base;
              s_cyc_q <= hit_onehot;
              s_stb_q <= hit_onehot;
              cnt_q   <= '0;
              state_q <= ACTIVE;
            end else begin
              // Error pulse lands in the cycle spent in ERROR.
              m_err_q <= 1'b1;
              m_dat_q <= '0;
              state_q <= ERROR;
            end
          end
        end
        ACTIVE: begin
          if (!m_cyc_i) begin
            // Master abandoned the cycle: release the slave silently.
            s_cyc_q <= '0;
            s_stb_q <= '0;
            state_q <= IDLE;
          end else if (sel_ack) begin
            if (!s_we_q) begin
              m_dat_q <= sel_dat;
            end
            m_ack_q <= 1'b1;
            s_cyc_q <= '0;
            s_stb_q <= '0;
            state_q <= RESP;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            m_err_q <= 1'b1;
            m_dat_q <= '0;
            s_cyc_q <= '0;
            s_stb_q <= '0;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ERROR: begin
          state_q <= RESP;
        end
        RESP: begin
          // Hold off a new decode until the master lowers its strobe.
          if (!m_stb_i) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Interrupt aggregate, registered once regardless of FSM state.
  always_comb begin
    m_int_d = |s_int_i;
  end

  // Interrupt register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      m_int_q <= 1'b0;
    end else begin
      m_int_q <= m_int_d;
    end
  end

  assign m_dat_o = m_dat_q;
  assign m_ack_o = m_ack_q;
  assign m_err_o = m_err_q;
  assign m_int_o = m_int_q;
  assign s_we_o  = s_we_q;
  assign s_cyc_o = s_cyc_q;
  assign s_stb_o = s_stb_q;
  assign s_sel_o = s_sel_q;
  assign s_adr_o = s_adr_q;
  assign s_dat_o = s_dat_q;

endmodule

// File: tb/tb_wishbone_mem_interconnect_n.sv
// Directed testbench for wishbone_mem_interconnect_n: a four-slave map for the
// main scenarios and a two-slave overlapping map for priority decode.
module tb_wishbone_mem_interconnect_n;

  logic         clk;
  logic         rst;
  logic         m_we;
  logic         m_cyc;
  logic         m_stb;
  logic [3:0]   m_sel;
  logic [31:0]  m_adr;
  logic [31:0]  m_wdat;
  logic [31:0]  m_rdat;
  logic         m_ack;
  logic         m_err;
  logic         m_int;
  logic         s_we;
  logic [3:0]   s_cyc;
  logic [3:0]   s_stb;
  logic [3:0]   s_sel;
  logic [31:0]  s_adr;
  logic [31:0]  s_wdat;
  logic [127:0] s_rdat;
  logic [3:0]   s_ack;
  logic [3:0]   s_int;

  logic         b_cyc;
  logic         b_stb;
  logic [31:0]  b_m_rdat;
  logic         b_m_ack;
  logic         b_m_err;
  logic         b_m_int;
  logic         b_s_we;
  logic [1:0]   b_s_cyc;
  logic [1:0]   b_s_stb;
  logic [3:0]   b_s_sel;
  logic [31:0]  b_s_adr;
  logic [31:0]  b_s_wdat;

  int n_chk;
  int n_pass;

  wishbone_mem_interconnect_n #(
    .NUM_SLAVES (4),
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .SLAVE_BASE ({32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
    .SLAVE_MASK ({4{32'hF000_0000}}),
    .TIMEOUT    (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .m_we_i  (m_we),
    .m_cyc_i (m_cyc),
    .m_stb_i (m_stb),
    .m_sel_i (m_sel),
    .m_adr_i (m_adr),
    .m_dat_i (m_wdat),
    .m_dat_o (m_rdat),
    .m_ack_o (m_ack),
    .m_err_o (m_err),
    .m_int_o (m_int),
    .s_we_o  (s_we),
    .s_cyc_o (s_cyc),
    .s_stb_o (s_stb),
    .s_sel_o (s_sel),
    .s_adr_o (s_adr),
    .s_dat_o (s_wdat),
    .s_dat_i (s_rdat),
    .s_ack_i (s_ack),
    .s_int_i (s_int)
  );

  // Overlapping map: slave0 matches everything, slave1 matches 0x0xxx_xxxx.
  wishbone_mem_interconnect_n #(
    .NUM_SLAVES (2),
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .SLAVE_BASE ({32'h0000_0000, 32'h0000_0000}),
    .SLAVE_MASK ({32'hF000_0000, 32'h0000_0000}),
    .TIMEOUT    (8)
  ) dut_ovl (
    .clk     (clk),
    .rst     (rst),
    .m_we_i  (m_we),
    .m_cyc_i (b_cyc),
    .m_stb_i (b_stb),
    .m_sel_i (m_sel),
    .m_adr_i (m_adr),
    .m_dat_i (m_wdat),
    .m_dat_o (b_m_rdat),
    .m_ack_o (b_m_ack),
    .m_err_o (b_m_err),
    .m_int_o (b_m_int),
    .s_we_o  (b_s_we),
    .s_cyc_o (b_s_cyc),
    .s_stb_o (b_s_stb),
    .s_sel_o (b_s_sel),
    .s_adr_o (b_s_adr),
    .s_dat_o (b_s_wdat),
    .s_dat_i (64'h0),
    .s_ack_i (2'b00),
    .s_int_i (2'b00)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Advance one clock; everything after returns lies 1 ns past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic we, input logic [31:0] adr,
                     input logic [31:0] dat, input logic [3:0] sel);
    m_we   = we;
    m_adr  = adr;
    m_wdat = dat;
    m_sel  = sel;
    m_cyc  = 1'b1;
    m_stb  = 1'b1;
  endtask

  task automatic drop();
    m_cyc = 1'b0;
    m_stb = 1'b0;
    m_we  = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst    = 1'b0;
    m_we   = 1'b0;
    m_cyc  = 1'b0;
    m_stb  = 1'b0;
    m_sel  = 4'h0;
    m_adr  = 32'h0;
    m_wdat = 32'h0;
    s_rdat = 128'h0;
    s_ack  = 4'h0;
    s_int  = 4'h0;
    b_cyc  = 1'b0;
    b_stb  = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_ack", m_ack, 1'b0);
    chk("rst_err", m_err, 1'b0);
    chk("rst_dat", m_rdat, 32'h0);
    chk("rst_stb", s_stb, 4'h0);
    chk("rst_cyc", s_cyc, 4'h0);
    chk("rst_adr", s_adr, 32'h0);
    chk("rst_int", m_int, 1'b0);
    rst = 1'b1;
    tick();

    // Read from slave2, ack three cycles after the strobe appears
    req(1'b0, 32'h2000_0040, 32'h0, 4'hF);
    tick();
    chk("rd_stb", s_stb, 4'b0100);
    chk("rd_cyc", s_cyc, 4'b0100);
    chk("rd_adr", s_adr, 32'h0000_0040);
    chk("rd_we", s_we, 1'b0);
    // A stray ack from a non-selected slave must be ignored.
    s_ack = 4'b0001;
    tick();
    s_ack = 4'b0000;
    chk("rd_stray_ack", m_ack, 1'b0);
    tick();
    tick();
    s_rdat[2*32 +: 32] = 32'hDEAD_BEEF;
    s_ack = 4'b0100;
    tick();
    s_ack = 4'b0000;
    chk("rd_ack", m_ack, 1'b1);
    chk("rd_noerr", m_err, 1'b0);
    chk("rd_dat", m_rdat, 32'hDEAD_BEEF);
    chk("rd_stb_drop", s_stb, 4'b0000);
    tick();
    chk("rd_ack_pulse", m_ack, 1'b0);
    drop();
    tick();

    // Write to slave1; request fields held until the ack
    req(1'b1, 32'h1000_0010, 32'hA5A5_0001, 4'b0011);
    tick();
    chk("wr_stb", s_stb, 4'b0010);
    chk("wr_we", s_we, 1'b1);
    chk("wr_sel", s_sel, 4'b0011);
    chk("wr_adr", s_adr, 32'h0000_0010);
    chk("wr_dat", s_wdat, 32'hA5A5_0001);
    m_adr  = 32'hFFFF_FFFF;
    m_wdat = 32'h0;
    m_sel  = 4'h0;
    tick();
    tick();
    chk("wr_hold_adr", s_adr, 32'h0000_0010);
    chk("wr_hold_dat", s_wdat, 32'hA5A5_0001);
    chk("wr_hold_sel", s_sel, 4'b0011);
    chk("wr_hold_we", s_we, 1'b1);
    s_ack = 4'b0010;
    tick();
    s_ack = 4'b0000;
    chk("wr_ack", m_ack, 1'b1);
    chk("wr_dat_keep", m_rdat, 32'hDEAD_BEEF);
    drop();
    tick();

    // Unmapped address: error in the first cycle, no strobe
    req(1'b0, 32'h4000_0000, 32'h0, 4'hF);
    tick();
    chk("um_err", m_err, 1'b1);
    chk("um_ack", m_ack, 1'b0);
    chk("um_stb", s_stb, 4'h0);
    chk("um_dat", m_rdat, 32'h0);
    tick();
    chk("um_err_pulse", m_err, 1'b0);
    // Strobe still high: no second decode or error
    tick();
    chk("um_resp_hold", m_err, 1'b0);
    chk("um_resp_stb", s_stb, 4'h0);
    drop();
    tick();

    // Timeout on slave0
    req(1'b0, 32'h0000_0100, 32'h0, 4'hF);
    tick();
    chk("to_stb", s_stb, 4'b0001);
    repeat (7) tick();
    chk("to_early_err", m_err, 1'b0);
    chk("to_early_stb", s_stb, 4'b0001);
    tick();
    chk("to_err", m_err, 1'b1);
    chk("to_ack", m_ack, 1'b0);
    chk("to_stb_drop", s_stb, 4'b0000);
    tick();
    chk("to_err_pulse", m_err, 1'b0);
    drop();
    tick();
    // Next transaction to slave0 acked at once: minimum latency
    req(1'b0, 32'h0000_0200, 32'h0, 4'hF);
    tick();
    s_rdat[0 +: 32] = 32'h1234_5678;
    s_ack = 4'b0001;
    tick();
    s_ack = 4'b0000;
    chk("to_next_ack", m_ack, 1'b1);
    chk("to_next_dat", m_rdat, 32'h1234_5678);
    drop();
    tick();

    // Overlapping map picks slave0
    m_adr = 32'h0000_0050;
    b_cyc = 1'b1;
    b_stb = 1'b1;
    tick();
    chk("ovl_stb", b_s_stb, 2'b01);
    chk("ovl_adr", b_s_adr, 32'h0000_0050);
    b_cyc = 1'b0;
    b_stb = 1'b0;
    tick();
    chk("ovl_abort", b_s_stb, 2'b00);

    // Master drops cyc while ACTIVE
    req(1'b0, 32'h1000_0020, 32'h0, 4'hF);
    tick();
    chk("ab_stb", s_stb, 4'b0010);
    drop();
    tick();
    chk("ab_stb_drop", s_stb, 4'b0000);
    chk("ab_cyc_drop", s_cyc, 4'b0000);
    chk("ab_noack", m_ack, 1'b0);
    chk("ab_noerr", m_err, 1'b0);
    s_ack = 4'b0010;
    tick();
    s_ack = 4'b0000;
    chk("ab_late_ack", m_ack, 1'b0);

    // Reset while ACTIVE
    req(1'b1, 32'h3000_0008, 32'h5555_AAAA, 4'hF);
    tick();
    chk("rs_stb", s_stb, 4'b1000);
    rst   = 1'b0;
    s_ack = 4'b1000;
    tick();
    s_ack = 4'b0000;
    chk("rs_stb_drop", s_stb, 4'h0);
    chk("rs_cyc_drop", s_cyc, 4'h0);
    chk("rs_adr", s_adr, 32'h0);
    chk("rs_wdat", s_wdat, 32'h0);
    chk("rs_we", s_we, 1'b0);
    chk("rs_dat", m_rdat, 32'h0);
    chk("rs_ack", m_ack, 1'b0);
    drop();
    rst = 1'b1;
    tick();

    // Interrupt pulse, once in IDLE and once in ACTIVE
    s_int = 4'b1000;
    chk("int_pre", m_int, 1'b0);
    tick();
    s_int = 4'b0000;
    chk("int_on", m_int, 1'b1);
    tick();
    chk("int_off", m_int, 1'b0);
    req(1'b0, 32'h0000_0000, 32'h0, 4'hF);
    tick();
    s_int = 4'b0010;
    tick();
    s_int = 4'b0000;
    chk("int_act_on", m_int, 1'b1);
    tick();
    chk("int_act_off", m_int, 1'b0);
    drop();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/wishbone_mem_interconnect_n.md
Name: wishbone_mem_interconnect_n

Overview:
Parametrised, registered single-master to N-slave Wishbone memory interconnect. It replaces the generated fixed-slave interconnect and sits between the host master and the memory slaves (SDRAM, block RAM, flash). It adds the following over a pure mux:
- base/mask address decode with per-slave offset subtraction
- a latched transaction FSM
- a bus-error response for unmapped addresses and for slave timeout
- a registered interrupt aggregate

Parameters:
NUM_SLAVES, 4, number of slave ports (1..16)
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width (multiple of 8)
SLAVE_BASE, {NUM_SLAVES*ADDR_WIDTH{1'b0}}, packed base addresses, slave i at [i*ADDR_WIDTH +: ADDR_WIDTH]
SLAVE_MASK, {NUM_SLAVES*ADDR_WIDTH{1'b0}}, packed decode masks; slave i hits when (m_adr_i & mask_i) == base_i
TIMEOUT, 255, cycles to wait for slave ack before error (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-low
m_we_i  in  1  master write enable
m_cyc_i  in  1  master cycle
m_stb_i  in  1  master strobe
m_sel_i  in  DATA_WIDTH/8  byte selects
m_adr_i  in  ADDR_WIDTH  master address
m_dat_i  in  DATA_WIDTH  master write data
m_dat_o  out  DATA_WIDTH  read data (registered)
m_ack_o  out  1  ack (registered, 1-cycle pulse)
m_err_o  out  1  bus error (registered, 1-cycle pulse)
m_int_o  out  1  registered OR of slave interrupts
s_we_o  out  1  shared write enable
s_cyc_o  out  NUM_SLAVES  per-slave cycle
s_stb_o  out  NUM_SLAVES  per-slave strobe
s_sel_o  out  DATA_WIDTH/8  shared byte selects
s_adr_o  out  ADDR_WIDTH  shared address, base-relative
s_dat_o  out  DATA_WIDTH  shared write data
s_dat_i  in  NUM_SLAVES*DATA_WIDTH  packed slave read data
s_ack_i  in  NUM_SLAVES  per-slave ack
s_int_i  in  NUM_SLAVES  per-slave interrupt

Behaviour:
- Reset (rst==0 at posedge): FSM=IDLE; all outputs 0; select index, timeout counter and latched request cleared. Reset mid-transaction drops s_cyc_o/s_stb_o the next cycle; a pending slave ack is ignored.
- FSM states:
  - IDLE: when m_cyc_i&m_stb_i, decode. Lowest-index hit wins.
    - Hit: latch index, we, sel, dat and (m_adr_i - base_i) onto s_*_o; assert s_cyc_o[idx], s_stb_o[idx]; counter=0; go to ACTIVE.
    - No hit: go to ERROR.
  - ACTIVE: counter increments each cycle.
    - s_ack_i[idx]: m_dat_o <= s_dat_i[idx] on reads (unchanged on writes); m_ack_o=1 for one cycle; deassert slave strobes; go to RESP.
    - Timeout (counter==TIMEOUT-1 without ack): m_err_o=1 for one cycle; m_dat_o <= 0; deassert strobes; go to RESP.
    - Ack wins over a simultaneous timeout.
    - m_cyc_i dropped: abort, deassert strobes, go to IDLE, no ack and no err.
  - ERROR: m_err_o=1 for one cycle, m_dat_o <= 0; go to RESP.
  - RESP: wait for m_stb_i==0, then go to IDLE. No new decode is accepted while m_stb_i stays high.
- Latency: request seen in IDLE at cycle 0; slave strobe at cycle 1; slave ack at cycle k gives m_ack_o at cycle k+1. Minimum master-visible latency is 2 cycles. Unmapped address gives m_err_o at cycle 1.
- m_ack_o and m_err_o are never high together, and are never high for more than one cycle.
- Non-selected slaves always see s_cyc_o/s_stb_o = 0. Acks from non-selected slaves are ignored.
- s_we_o, s_sel_o, s_adr_o and s_dat_o are held stable from strobe assertion until ack, timeout or abort.
- Address subtraction is modulo 2^ADDR_WIDTH.
- m_int_o is updated every cycle to |s_int_i, with one cycle of delay, independent of FSM state.

Test Plan:
- Bases 0x0000_0000/0x1000_0000/0x2000_0000/0x3000_0000, mask 0xF000_0000. Read 0x2000_0040, slave2 acks 3 cycles after strobe with 0xDEADBEEF -> s_stb_o=4'b0100, s_adr_o=0x40, m_dat_o=0xDEADBEEF, m_ack_o pulses once.
- Write 0x1000_0010 data 0xA5A5_0001, sel 4'b0011 -> slave1 sees we=1, sel=0011, dat and adr=0x10 stable until ack; m_dat_o unchanged.
- Same map with slave3 mask 0xF0000000 base 0x3000_0000; access 0x4000_0000 -> m_err_o at cycle 1, no s_stb_o asserted, m_dat_o=0.
- TIMEOUT=8, slave0 never acks -> m_err_o pulses exactly 8 cycles after strobe; strobe drops; next transaction succeeds.
- Overlapping maps (slave0 and slave1 both hit) -> slave0 selected. m_cyc_i dropped mid-ACTIVE -> strobes drop next cycle, no ack/err. rst=0 mid-ACTIVE -> all outputs 0 next cycle.
- s_int_i=4'b1000 pulse for 1 cycle -> m_int_o high for exactly 1 cycle, one cycle later, in any FSM state.
